init_seq_gen: RTL

INIT_SEQ_GEN -- requirements
Module: init_seq_gen

---
 rtl/init_seq_pkg.sv | 22 ++
 rtl/init_req_cond.sv | 35 +++
 rtl/init_seq_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/init_seq_pkg.sv
// Shared types for the init sequence generator: FSM state encoding and the
// sizing helper for the stretch/gap down-counter.
package init_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INIT     = 2'd1,
    ST_GAP      = 2'd2,
    ST_FIFO_RST = 2'd3
  } init_state_e;

  localparam int unsigned COUNT_W = 16;

  // One counter serves both the am_init stretch and the gap, so it is sized for the larger.
  function automatic int unsigned cnt_width(input int unsigned stretch,
                                            input int unsigned fifo_dly);
    int unsigned m;
    m = (stretch > fifo_dly) ? stretch : fifo_dly;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/init_req_cond.sv
// Request conditioning: applies the per-source mask and, in edge mode,
// keeps only sources that were low on the previous cycle.
module init_req_cond #(
  parameter int unsigned N_SRC     = 2,
  parameter int unsigned EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] init_req_i,
  input  logic [N_SRC-1:0] src_mask_i,
  output logic             trig_o,
  output logic [N_SRC-1:0] qual_src_o
);

  logic [N_SRC-1:0] req_d_q;

  // Resetting to all-ones means a request already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_d_q <= '1;
    end else begin
      req_d_q <= init_req_i;
    end
  end

  always_comb begin
    if (EDGE_MODE != 0) begin
      qual_src_o = init_req_i & ~req_d_q & src_mask_i;
    end else begin
      qual_src_o = init_req_i & src_mask_i;
    end
    trig_o = |qual_src_o;
  end

endmodule

// File: rtl/init_seq_gen.sv
// Init sequence generator: stretched am_init pulse, a gap, then a one-cycle
// active-low FIFO reset. Any qualified request restarts the stretch.
module init_seq_gen
  import init_seq_pkg::*;
#(
  parameter int unsigned N_SRC     = 2,
  parameter int unsigned STRETCH   = 4,
  parameter int unsigned FIFO_DLY  = 2,
  parameter int unsigned EDGE_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   init_req,
  input  logic [N_SRC-1:0]   src_mask,
  output logic               am_init,
  output logic               resfifon,
  output logic               busy,
  output logic [N_SRC-1:0]   init_src,
  output logic [COUNT_W-1:0] init_count,
  output init_state_e        state_dbg
);

  localparam int unsigned CW = cnt_width(STRETCH, FIFO_DLY);
  localparam logic [CW-1:0] CNT_STRETCH = CW'(STRETCH - 1);
  localparam logic [CW-1:0] CNT_GAP     = CW'(FIFO_DLY - 1);

  logic             trig;
  logic [N_SRC-1:0] qual_src;

  init_req_cond #(
    .N_SRC     (N_SRC),
    .EDGE_MODE (EDGE_MODE)
  ) u_req_cond (
    .clk        (clk),
    .rst        (rst),
    .init_req_i (init_req),
    .src_mask_i (src_mask),
    .trig_o     (trig),
    .qual_src_o (qual_src)
  );

  init_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               am_init_q, am_init_d;
  logic               resfifon_q, resfifon_d;
  logic               busy_q, busy_d;
  logic [N_SRC-1:0]   init_src_q, init_src_d;
  logic [COUNT_W-1:0] init_count_q, init_count_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    init_src_d   = init_src_q;
    init_count_d = init_count_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d    = ST_INIT;
          cnt_d      = CNT_STRETCH;
          init_src_d = qual_src;
          if (init_count_q != '1) begin
            init_count_d = init_count_q + COUNT_W'(1);
          end
        end
      end
      ST_INIT: begin
        if (trig) begin
          cnt_d      = CNT_STRETCH;
          init_src_d = init_src_q | qual_src;
        end else if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = CNT_GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (trig) begin
          state_d    = ST_INIT;
          cnt_d      = CNT_STRETCH;
          init_src_d = init_src_q | qual_src;
        end else if (cnt_q == '0) begin
          state_d = ST_FIFO_RST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FIFO_RST: begin
        if (trig) begin
          state_d    = ST_INIT;
          cnt_d      = CNT_STRETCH;
          init_src_d = init_src_q | qual_src;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are decoded from the next state so they register in step with it.
    am_init_d  = (state_d == ST_INIT);
    resfifon_d = (state_d != ST_FIFO_RST);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      am_init_q    <= 1'b0;
      resfifon_q   <= 1'b1;
      busy_q       <= 1'b0;
      init_src_q   <= '0;
      init_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      am_init_q    <= am_init_d;
      resfifon_q   <= resfifon_d;
      busy_q       <= busy_d;
      init_src_q   <= init_src_d;
      init_count_q <= init_count_d;
    end
  end

  assign am_init    = am_init_q;
  assign resfifon   = resfifon_q;
  assign busy       = busy_q;
  assign init_src   = init_src_q;
  assign init_count = init_count_q;
  assign state_dbg  = state_q;

endmodule
